// File: rtl/bcd_pkg.sv
// Shared types, constants and helpers for the digit-serial BCD add/sub stage.
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ADD,
      RECOMP,
      DONE
   } state_t;

   localparam logic [3:0] BCD_MAX  = 4'd9;
   localparam logic [3:0] BCD_CORR = 4'd6;

   function automatic logic [3:0] nines_comp(input logic [3:0] d);
      return BCD_MAX - d;
   endfunction

endpackage

// File: rtl/bcd_digit_adder.sv
// One-digit BCD adder with decimal correction; shared by the add and
// recomplement passes.
module bcd_digit_adder
   import bcd_pkg::*;
(
   input  logic [3:0] x,
   input  logic [3:0] y,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);

   logic [4:0] s;

   always_comb begin
      s    = {1'b0, x} + {1'b0, y} + {4'b0, cin};
      sum  = s[3:0];
      cout = 1'b0;
      if (s > {1'b0, BCD_MAX}) begin
         sum  = s[3:0] + BCD_CORR;
         cout = 1'b1;
      end
   end

endmodule

// File: rtl/bcd_serial_addsub.sv
// Digit-serial NDIG-digit BCD adder/subtractor, LSD first; negative
// differences are recomplemented to sign-magnitude in a second pass.
module bcd_serial_addsub
   import bcd_pkg::*;
#(
   parameter int NDIG = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              m,
   input  logic [4*NDIG-1:0] a,
   input  logic [4*NDIG-1:0] b,
   output logic [4*NDIG-1:0] result,
   output logic              cout,
   output logic              neg,
   output logic              err,
   output logic              busy,
   output logic              done
);

   localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [IW-1:0] LAST = IW'(NDIG - 1);

   state_t            state;
   logic [IW-1:0]     idx;
   logic              carry;
   logic              m_q;
   logic [4*NDIG-1:0] a_q;
   logic [4*NDIG-1:0] b_q;

   logic [3:0] a_dig;
   logic [3:0] b_dig;
   logic [3:0] r_dig;
   logic [3:0] x;
   logic [3:0] y;
   logic [3:0] sum_d;
   logic       co;
   logic       bad_in;

   always_comb begin
      a_dig = '0;
      b_dig = '0;
      r_dig = '0;
      for (int i = 0; i < NDIG; i++) begin
         if (idx == IW'(i)) begin
            a_dig = a_q[4*i +: 4];
            b_dig = b_q[4*i +: 4];
            r_dig = result[4*i +: 4];
         end
      end
   end

   // Recomplement reuses the adder: 9's(result digit) + carry.
   always_comb begin
      x = a_dig;
      y = m_q ? nines_comp(b_dig) : b_dig;
      if (state == RECOMP) begin
         x = nines_comp(r_dig);
         y = '0;
      end
   end

   always_comb begin
      bad_in = 1'b0;
      for (int i = 0; i < NDIG; i++) begin
         if (a[4*i +: 4] > BCD_MAX) bad_in = 1'b1;
         if (b[4*i +: 4] > BCD_MAX) bad_in = 1'b1;
      end
   end

   bcd_digit_adder u_dig (
      .x    (x),
      .y    (y),
      .cin  (carry),
      .sum  (sum_d),
      .cout (co)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         idx    <= '0;
         carry  <= 1'b0;
         m_q    <= 1'b0;
         a_q    <= '0;
         b_q    <= '0;
         result <= '0;
         cout   <= 1'b0;
         neg    <= 1'b0;
         err    <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  a_q    <= a;
                  b_q    <= b;
                  m_q    <= m;
                  result <= '0;
                  cout   <= 1'b0;
                  neg    <= 1'b0;
                  idx    <= '0;
                  carry  <= m;
                  busy   <= 1'b1;
                  if (bad_in) begin
                     err   <= 1'b1;
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     err   <= 1'b0;
                     state <= ADD;
                  end
               end
            end
            ADD: begin
               result[4*int'(idx) +: 4] <= sum_d;
               carry <= co;
               if (idx == LAST) begin
                  idx <= '0;
                  if (!m_q) begin
                     cout  <= co;
                     done  <= 1'b1;
                     state <= DONE;
                  end else if (co) begin
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     neg   <= 1'b1;
                     carry <= 1'b1;
                     state <= RECOMP;
                  end
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            RECOMP: begin
               result[4*int'(idx) +: 4] <= sum_d;
               carry <= co;
               if (idx == LAST) begin
                  idx   <= '0;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Bench for bcd_serial_addsub: directed table, corner sequences and
// randomized operations against an integer-arithmetic model.
module tb_bcd_serial_addsub;

   localparam int NDIG = 2;
   localparam int W = 4 * NDIG;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         m = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic [W-1:0] result;
   logic         cout;
   logic         neg;
   logic         err;
   logic         busy;
   logic         done;

   int n_cmp = 0;
   int n_bad = 0;

   bcd_serial_addsub #(.NDIG(NDIG)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .m      (m),
      .a      (a),
      .b      (b),
      .result (result),
      .cout   (cout),
      .neg    (neg),
      .err    (err),
      .busy   (busy),
      .done   (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         m;
      logic [W-1:0] res;
      logic         co;
      logic         ng;
      logic         er;
      int           lat;
   } vec_t;

   task automatic check(input string name, input longint act,
                        input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int bcd_val(input logic [W-1:0] v);
      int r = 0;
      for (int i = NDIG - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
      return r;
   endfunction

   function automatic logic [W-1:0] to_bcd(input int v);
      logic [W-1:0] r = '0;
      for (int i = 0; i < NDIG; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   function automatic logic has_bad(input logic [W-1:0] v);
      for (int i = 0; i < NDIG; i++)
         if (v[4*i +: 4] > 4'd9) return 1'b1;
      return 1'b0;
   endfunction

   // Reference: plain decimal arithmetic on whole operands.
   function automatic vec_t model(input logic [W-1:0] va,
                                  input logic [W-1:0] vb,
                                  input logic vm);
      vec_t v;
      int   lim = 1;
      int   s;
      for (int i = 0; i < NDIG; i++) lim *= 10;
      v.a = va; v.b = vb; v.m = vm;
      v.res = '0; v.co = 0; v.ng = 0; v.er = 0;
      if (has_bad(va) || has_bad(vb)) begin
         v.er = 1; v.lat = 1;
      end else if (!vm) begin
         s = bcd_val(va) + bcd_val(vb);
         v.co = (s >= lim);
         v.res = to_bcd(s % lim);
         v.lat = NDIG + 1;
      end else begin
         s = bcd_val(va) - bcd_val(vb);
         v.ng = (s < 0);
         v.res = to_bcd(s < 0 ? -s : s);
         v.lat = v.ng ? 2 * NDIG + 1 : NDIG + 1;
      end
      return v;
   endfunction

   task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic vm, output int lat);
      a = va; b = vb; m = vm; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 1;
      while (!done && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic apply(input vec_t v, input string tag);
      int lat;
      run_op(v.a, v.b, v.m, lat);
      check({tag, " done"}, done, 1);
      check({tag, " latency"}, lat, v.lat);
      check({tag, " result"}, result, v.res);
      check({tag, " cout"}, cout, v.co);
      check({tag, " neg"}, neg, v.ng);
      check({tag, " err"}, err, v.er);
      check({tag, " busy"}, busy, 1);
      @(posedge clk); #1;
      check({tag, " idle"}, busy, 0);
   endtask

   vec_t tbl[8];

   initial begin
      int   lat;
      vec_t v;
      logic [W-1:0] ra, rb;

      tbl[0] = '{8'h45, 8'h37, 1'b0, 8'h82, 1'b0, 1'b0, 1'b0, 3};
      tbl[1] = '{8'h99, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3};
      tbl[2] = '{8'h45, 8'h37, 1'b1, 8'h08, 1'b0, 1'b0, 1'b0, 3};
      tbl[3] = '{8'h37, 8'h45, 1'b1, 8'h08, 1'b0, 1'b1, 1'b0, 5};
      tbl[4] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 3};
      tbl[5] = '{8'h3A, 8'h12, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1};
      tbl[6] = '{8'h00, 8'h99, 1'b1, 8'h99, 1'b0, 1'b1, 1'b0, 5};
      tbl[7] = '{8'h12, 8'hF0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1};

      #12;
      check("rst result", result, 0);
      check("rst flags", {cout, neg, err, busy, done}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 8; i++) apply(tbl[i], $sformatf("vec%0d", i));

      // start while busy is ignored
      a = 8'h45; b = 8'h37; m = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      a = 8'h99; b = 8'h99; m = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 2;
      while (!done && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      check("busy-start lat", lat, 3);
      check("busy-start result", result, 8'h82);
      // start in the done cycle is ignored too
      a = 8'h11; b = 8'h11; m = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("done-start busy", busy, 0);
      @(posedge clk); #1;
      check("done-start hold", result, 8'h82);
      check("done-start busy2", busy, 0);

      // async reset in the middle of RECOMP
      a = 8'h37; b = 8'h45; m = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst result", result, 0);
      check("midrst flags", {cout, neg, err, busy, done}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      apply(model(8'h20, 8'h53, 1'b1), "after-rst");

      // randomized against the decimal model
      for (int k = 0; k < 200; k++) begin
         ra = '0; rb = '0;
         for (int i = 0; i < NDIG; i++) begin
            ra[4*i +: 4] = 4'($urandom_range(0, 9));
            rb[4*i +: 4] = 4'($urandom_range(0, 9));
         end
         if ($urandom_range(0, 15) == 0)
            ra[4*$urandom_range(0, NDIG-1) +: 4] = 4'($urandom_range(10, 15));
         if ($urandom_range(0, 15) == 0)
            rb[4*$urandom_range(0, NDIG-1) +: 4] = 4'($urandom_range(10, 15));
         v = model(ra, rb, 1'($urandom_range(0, 1)));
         apply(v, $sformatf("rnd%0d", k));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
